frame_buffer_reader: RTL and testbench
======================================

Name: frame_buffer_reader

Overview:
- Read-side controller for the camera frame buffer RAM.
- On a start pulse it scans one stored frame in raster order. It drives the RAM read address and read-enable, and captures the RAM's registered read data.
- It streams pixels downstream over a valid/ready handshake, with start-of-frame, end-of-line and end-of-frame markers.
- It sits between the frame buffer and the pixel consumer (display/processing path). The camera capture logic owns the RAM write side.

Parameters:
- H_PIXELS, 160, pixels per line.
- V_LINES, 120, lines per frame.
- ADDR_W, 15, RAM address width.
- DATA_W, 8, pixel width.
- BASE_ADDR, 0, RAM address of the first frame pixel. Constraint: BASE_ADDR + H_PIXELS*V_LINES - 1 < 2**ADDR_W, so there is no address wrap.

Ports:
- i_clk  in  1  clock. All logic is on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Start  in  1  single-cycle pulse requesting one frame readout.
- o_Read_Adress  out  ADDR_W  RAM read address.
- o_Enable_Read  out  1  RAM read enable.
- i_Data  in  DATA_W  RAM read data.
- o_Data  out  DATA_W  pixel to consumer.
- o_Valid  out  1  o_Data and markers are valid.
- i_Ready  in  1  consumer accepts the pixel this cycle.
- o_Start_Of_Frame  out  1  qualifies o_Valid: first pixel (x=0, y=0).
- o_End_Of_Line  out  1  qualifies o_Valid: x = H_PIXELS-1.
- o_End_Of_Frame  out  1  qualifies o_Valid: last pixel of the frame.
- o_Busy  out  1  frame readout in progress.
- o_Done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (asynchronous, clears everything):
  - FSM goes to IDLE.
  - Address, x and y counters go to BASE_ADDR/0/0.
  - Output buffer is emptied.
  - o_Valid, o_Enable_Read, o_Busy, o_Done, all markers = 0.
  - o_Data = 0.
  - o_Read_Adress = BASE_ADDR.
- RAM timing contract: an issue in cycle N (o_Enable_Read=1, address A) yields i_Data = mem[A] by the end of cycle N. The reader captures it at the rising edge ending cycle N. When o_Enable_Read=0 the RAM holds its output; the reader ignores i_Data.
- Output buffer: 2 entries, each holding pixel + SOF/EOL/EOF sideband, in FIFO order. o_Data and markers always reflect the head entry.
  - pop = o_Valid & i_Ready.
  - o_Valid = buffer not empty.
- Issue rule: o_Enable_Read = (state==READ) & (occupancy < 2 | pop). It is combinational from i_Ready, so that path is accepted. Each issue:
  - captures the pixel into the buffer at the cycle's end;
  - advances the address by 1;
  - increments x, wrapping to 0 at H_PIXELS-1 and then incrementing y.
- Markers are computed from x/y at issue time and stored with the pixel.
- FSM:
  - IDLE: o_Busy=0. i_Start moves to READ next cycle; counters already hold their start values.
  - READ: o_Busy=1. Issues per the rule. The issue of the last pixel (x=H_PIXELS-1, y=V_LINES-1) moves to DRAIN.
  - DRAIN: o_Busy=1, no issues. Popping the EOF entry moves to IDLE, restores BASE_ADDR/0/0, and registers o_Done=1 for exactly the next cycle.
- i_Start while o_Busy=1 is ignored, with no restart and no queuing. i_Start in the same cycle as the o_Done pulse is accepted.
- Latency and throughput:
  - i_Start in cycle 0 gives first issue in cycle 1 and o_Valid in cycle 2.
  - With i_Ready held high: one pixel per clock, no bubbles, including across line boundaries.
- Backpressure: while i_Ready=0 and the buffer is full, there are no issues and o_Data/o_Valid/markers hold. No pixel is lost or duplicated.
- The RAM address is a running counter. There is no y*H_PIXELS multiply.
- Reset mid-frame: immediate abort to the reset state. The partial frame is discarded and no o_Done is produced.

Test Plan:
- Frame with i_Ready=1 (defaults), RAM preloaded mem[k]=k[7:0] → i_Start at cycle 0:
  - first o_Valid at cycle 2 with o_Start_Of_Frame=1 and o_Data=0;
  - 19200 consecutive valid pixels equal to k[7:0];
  - o_End_Of_Line exactly on every 160th pixel;
  - o_End_Of_Frame on pixel 19199 at cycle 19201;
  - o_Done pulse at cycle 19202, o_Busy=0 at cycle 19202.
- H_PIXELS=4, V_LINES=2, BASE_ADDR=100 → o_Read_Adress sequence 100..107; EOL on pixels 3 and 7; EOF on 7; o_Read_Adress returns to 100 after o_Done.
- Backpressure: i_Ready low for 5 cycles mid-line, then a random 50% ready pattern → o_Enable_Read=0 while the buffer is full; o_Data stable while stalled; the output sequence is identical to the no-stall run.
- i_Start pulsed again at cycles 10 and 500 during a frame → ignored; exactly one o_Done. i_Start coincident with o_Done → a second frame starts, o_Valid two cycles later.
- i_Reset asserted asynchronously mid-cycle at pixel 300 → all outputs 0 immediately, FSM in IDLE, no o_Done. The next i_Start restarts at BASE_ADDR with o_Start_Of_Frame.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: read-side controller for the camera frame buffer RAM.
// A start pulse scans one stored frame in raster order, issuing RAM reads and
// streaming pixels downstream through a 2-entry buffer over valid/ready.
//
// Ports:
//   i_clk, i_Reset        clock (rising edge), async active-high reset
//   i_Start               one-cycle request for a frame readout
//   o_Read_Adress         RAM read address
//   o_Enable_Read         RAM read enable (combinational from i_Ready)
//   i_Data                RAM read data, valid by the end of the issue cycle
//   o_Data, o_Valid       head pixel of the output buffer and its valid
//   i_Ready               consumer accepts the head pixel this cycle
//   o_Start_Of_Frame, o_End_Of_Line, o_End_Of_Frame  head-pixel markers
//   o_Busy                frame readout in progress
//   o_Done                one-cycle pulse after the EOF pixel is accepted
module frame_buffer_reader #(
  parameter int unsigned H_PIXELS  = 160,
  parameter int unsigned V_LINES   = 120,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_Reset,
  input  logic              i_Start,
  output logic [ADDR_W-1:0] o_Read_Adress,
  output logic              o_Enable_Read,
  input  logic [DATA_W-1:0] i_Data,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic              o_Start_Of_Frame,
  output logic              o_End_Of_Line,
  output logic              o_End_Of_Frame,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned EW = DATA_W + 3;
  localparam logic [XW-1:0]     XLast    = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]     YLast    = YW'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  // Buffer entry layout: {sof, eol, eof, pixel}; ent0 is always the head.
  logic [EW-1:0]     ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              pop, issue, last_px, head_eof;
  logic              new_sof, new_eol, new_eof;
  logic [EW-1:0]     new_ent;

  assign o_Valid  = (cnt_q != 2'd0);
  assign pop      = o_Valid & i_Ready;
  assign issue    = (state_q == StRead) & ((cnt_q != 2'd2) | pop);
  assign last_px  = (x_q == XLast) && (y_q == YLast);
  assign head_eof = ent0_q[DATA_W];

  // Markers come from the counters at issue time; the pixel arrives by the
  // end of the same cycle, so both are written into the buffer together.
  assign new_sof = (x_q == '0) && (y_q == '0);
  assign new_eol = (x_q == XLast);
  assign new_eof = last_px;
  assign new_ent = {new_sof, new_eol, new_eof, i_Data};

  assign o_Read_Adress    = addr_q;
  assign o_Enable_Read    = issue;
  assign o_Data           = ent0_q[DATA_W-1:0];
  assign o_Start_Of_Frame = o_Valid & ent0_q[DATA_W+2];
  assign o_End_Of_Line    = o_Valid & ent0_q[DATA_W+1];
  assign o_End_Of_Frame   = o_Valid & ent0_q[DATA_W];
  assign o_Busy           = (state_q != StIdle);
  assign o_Done           = done_q;

  // Sequencer and address/raster counters.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;

    if (issue) begin
      addr_d = addr_q + 1'b1;
      if (x_q == XLast) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    case (state_q)
      StIdle:  if (i_Start) state_d = StRead;
      StRead:  if (issue && last_px) state_d = StDrain;
      StDrain: begin
        if (pop && head_eof) begin
          state_d = StIdle;
          done_d  = 1'b1;
          addr_d  = AddrBase;
          x_d     = '0;
          y_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Two-entry FIFO kept as a shift pair so the head never moves in the mux.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({issue, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= StIdle;
      addr_q  <= AddrBase;
      x_q     <= '0;
      y_q     <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader: a full-size instance (160x120, base 0)
// and a small instance (4x2, base 100), both reading a RAM holding mem[k]=k[7:0].
module tb_frame_buffer_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] mem [0:32767];

  // Full-size instance.
  logic        start_a, ready_a, en_a, valid_a, sof_a, eol_a, eof_a, busy_a, done_a;
  logic [14:0] addr_a;
  logic [7:0]  din_a, data_a, hold_a;
  assign din_a = en_a ? mem[addr_a] : hold_a;
  always @(posedge clk) if (en_a) hold_a <= mem[addr_a];

  frame_buffer_reader dut_a (
    .i_clk(clk), .i_Reset(rst), .i_Start(start_a),
    .o_Read_Adress(addr_a), .o_Enable_Read(en_a), .i_Data(din_a),
    .o_Data(data_a), .o_Valid(valid_a), .i_Ready(ready_a),
    .o_Start_Of_Frame(sof_a), .o_End_Of_Line(eol_a), .o_End_Of_Frame(eof_a),
    .o_Busy(busy_a), .o_Done(done_a)
  );

  // Small instance.
  logic        start_b, ready_b, en_b, valid_b, sof_b, eol_b, eof_b, busy_b, done_b;
  logic [14:0] addr_b;
  logic [7:0]  din_b, data_b, hold_b;
  assign din_b = en_b ? mem[addr_b] : hold_b;
  always @(posedge clk) if (en_b) hold_b <= mem[addr_b];

  frame_buffer_reader #(.H_PIXELS(4), .V_LINES(2), .BASE_ADDR(100)) dut_b (
    .i_clk(clk), .i_Reset(rst), .i_Start(start_b),
    .o_Read_Adress(addr_b), .o_Enable_Read(en_b), .i_Data(din_b),
    .o_Data(data_b), .o_Valid(valid_b), .i_Ready(ready_b),
    .o_Start_Of_Frame(sof_b), .o_End_Of_Line(eol_b), .o_End_Of_Frame(eof_b),
    .o_Busy(busy_b), .o_Done(done_b)
  );

  logic [31:0] obs_a, obs_b;
  assign obs_a = {20'd0, valid_a, sof_a, eol_a, eof_a, data_a};
  assign obs_b = {20'd0, valid_b, sof_b, eol_b, eof_b, data_b};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {valid, sof, eol, eof, pixel} for raster index idx.
  function automatic logic [31:0] px_exp(int idx, int h, int v, int base);
    logic [7:0] d;
    d = 8'(base + idx);
    return {20'd0, 1'b1, (idx == 0), ((idx % h) == h - 1), (idx == h * v - 1), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones, k, stall, cyc;
    logic stalled_done, prev_hold;
    logic [31:0] prev_px;

    for (int i = 0; i < 32768; i++) mem[i] = i[7:0];
    rst = 1'b1;
    start_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; ready_b = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_out_a", 32'({valid_a, en_a, busy_a, done_a, sof_a, eol_a, eof_a, data_a}), 32'd0);
    check("rst_addr_a", 32'(addr_a), 32'd0);
    check("rst_out_b", 32'({valid_b, en_b, busy_b, done_b, sof_b, eol_b, eof_b, data_b}), 32'd0);
    check("rst_addr_b", 32'(addr_b), 32'd100);
    tick();
    rst = 1'b0;

    // Small frame: addresses 100..107, EOL on pixels 3 and 7, EOF on 7.
    tick();
    start_b = 1'b1;
    #1;
    check("b_idle_busy", 32'(busy_b), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_b = 1'b0;
      #1;
      if (c <= 8) check("b_issue", 32'({en_b, addr_b}), 32'({1'b1, 15'(100 + c - 1)}));
      if (c >= 2 && c <= 9) check("b_px", obs_b, px_exp(c - 2, 4, 2, 100));
      if (c == 10)
        check("b_done", 32'({done_b, busy_b, valid_b, addr_b}), 32'({3'b100, 15'd100}));
    end
    tick();
    #1;
    check("b_done_pulse", 32'(done_b), 32'd0);

    // Full frame with ready high; stray starts at cycles 10 and 500, and a
    // start coincident with o_Done at cycle 19202.
    tick();
    start_a = 1'b1;
    #1;
    dones = 0;
    for (int c = 1; c <= 19202; c++) begin
      tick();
      start_a = (c == 10 || c == 500 || c == 19202);
      #1;
      if (done_a) dones++;
      if (c == 1) check("f1_first_issue", 32'({en_a, busy_a, valid_a}), 32'b110);
      if (c >= 2 && c <= 19201) check("f1_px", obs_a, px_exp(c - 2, 160, 120, 0));
      if (c == 19202) begin
        check("f1_done", 32'({done_a, busy_a, valid_a}), 32'b100);
        check("f1_done_count", 32'(dones), 32'd1);
      end
    end

    // Second frame: 5-cycle stall at pixel 50, then random ready.
    tick();
    start_a = 1'b0;
    #1;
    check("f2_first_issue", 32'({en_a, busy_a, valid_a, done_a}), 32'b1100);
    k = 0; stall = 0; cyc = 0; dones = 0;
    stalled_done = 1'b0; prev_hold = 1'b0; prev_px = '0;
    while (k < 300 && cyc < 5000) begin
      tick();
      cyc++;
      if (!stalled_done && k == 50) begin
        stall = 5;
        stalled_done = 1'b1;
      end
      if (stall > 0)         ready_a = 1'b0;
      else if (stalled_done) ready_a = 1'($urandom_range(0, 1));
      else                   ready_a = 1'b1;
      #1;
      if (done_a) dones++;
      if (prev_hold) check("f2_hold", obs_a, prev_px);
      check("f2_px", obs_a, px_exp(k, 160, 120, 0));
      if (stall > 0 && stall <= 3) check("f2_full_no_issue", 32'(en_a), 32'd0);
      prev_hold = valid_a & ~ready_a;
      prev_px = obs_a;
      if (valid_a && ready_a) k++;
      if (stall > 0) stall--;
    end
    check("f2_reached_300", 32'(k), 32'd300);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", 32'({valid_a, en_a, busy_a, done_a, sof_a, eol_a, eof_a, data_a}), 32'd0);
    check("arst_addr", 32'(addr_a), 32'd0);
    check("f2_no_done", 32'(dones), 32'd0);
    ready_a = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_idle", 32'({done_a, busy_a, valid_a}), 32'd0);
    end

    // Restart after reset begins at BASE_ADDR with SOF.
    tick();
    start_a = 1'b1;
    #1;
    tick();
    start_a = 1'b0;
    #1;
    check("f3_issue", 32'({en_a, busy_a, addr_a}), 32'({2'b11, 15'd0}));
    tick();
    check("f3_sof", obs_a, px_exp(0, 160, 120, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
